dpwm_gen: RTL and testbench

- Downstream consumer of the 10-bit duty counter: turns its duty word (0..1000, steps of 25) into a complementary PWM pair with dead time.
- Free-running period counter compares against a shadow duty register that updates only at period boundaries (glitch-free).
- Registered gate outputs drive the power-stage high-side/low-side switches.

---
 rtl/dpwm_gen.sv | 176 +++++++++++++++++
 tb/tb_dpwm_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_gen.sv
// ============================================================================
// dpwm_gen
// ----------------------------------------------------------------------------
// Complementary PWM generator with dead time. Takes the duty word from the
// upstream duty counter and turns it into a high-side / low-side gate pair.
// The two gates are never on together, and both are held low for DEADTIME
// clocks at every switch transition.
//
// A free-running period counter (0..PERIOD-1) is compared against a shadow
// copy of the duty word. The shadow only reloads at period boundaries, so a
// duty change never produces a runt pulse in the middle of a period.
//
// Ports
//   clkm          in   system clock, rising edge
//   reset         in   asynchronous reset, active-low (0 = reset)
//   en            in   run enable; 0 forces idle (gates off, counter at 0)
//   duty_in       in   requested duty in clocks (clamped to PERIOD)
//   pwm_h         out  high-side gate, registered
//   pwm_l         out  low-side gate, registered
//   period_start  out  one-clock pulse in the first cycle of each period
//   duty_active   out  duty value currently in effect (shadow register)
//
// Parameters
//   WIDTH     width of duty word and period counter
//   PERIOD    clocks per PWM period, PERIOD <= 2**WIDTH
//   DEADTIME  clocks of both-low at each transition, >= 1
// ============================================================================
module dpwm_gen #(
  parameter int WIDTH    = 10,
  parameter int PERIOD   = 1000,
  parameter int DEADTIME = 4
) (
  input  logic             clkm,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active
);

  // The clamp ceiling is PERIOD, except when PERIOD == 2**WIDTH, where the
  // largest representable duty word is the best available approximation.
  localparam int               DMAX    = (PERIOD > (2**WIDTH) - 1) ? (2**WIDTH) - 1 : PERIOD;
  localparam logic [WIDTH-1:0] DMAX_W  = WIDTH'(DMAX);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(PERIOD - 1);
  localparam int               DTW     = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DTW-1:0]   DT_LAST = DTW'(DEADTIME - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DT   = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [DTW-1:0]   dt_cnt;

  logic [WIDTH-1:0] dclamp;
  logic             raw;
  logic             running;
  logic             start;
  logic             wrap;

  // Combinational helpers. raw is the undelayed PWM waveform: duty 0 keeps it
  // low for the whole period, duty PERIOD keeps it high for the whole period.
  // start marks the IDLE->run edge, wrap marks the last count of a period;
  // both are the only moments the shadow duty register may reload.
  always_comb begin
    dclamp  = (duty_in > DMAX_W) ? DMAX_W : duty_in;
    raw     = (cnt < duty_active);
    running = en && (state != IDLE);
    start   = en && (state == IDLE);
    wrap    = running && (cnt == LAST);
  end

  // Period counter, shadow duty register and period_start pulse. The counter
  // sits at 0 whenever the generator is idle or disabled so every run begins
  // with a full period. duty_active is intentionally kept across a disable so
  // the last applied duty stays visible.
  always_ff @(posedge clkm or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      duty_active  <= '0;
      period_start <= 1'b0;
    end else begin
      if (running) begin
        cnt <= wrap ? '0 : cnt + WIDTH'(1);
      end else begin
        cnt <= '0;
      end
      if (wrap || start) begin
        duty_active <= dclamp;
      end
      period_start <= wrap || start;
    end
  end

  // Gate FSM. Outputs are assigned together with the next state so each gate
  // is a plain flop decoded from where the FSM is heading. Every route into
  // HIGH or LOW passes through DT, which guarantees the dead time. The DT exit
  // target is raw sampled on the last dead-time clock, so a raw pulse no
  // longer than DEADTIME is absorbed entirely.
  always_ff @(posedge clkm or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else if (!en) begin
      state  <= IDLE;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= DT;
          dt_cnt <= '0;
          pwm_h  <= 1'b0;
          pwm_l  <= 1'b0;
        end
        DT: begin
          if (dt_cnt == DT_LAST) begin
            dt_cnt <= '0;
            if (raw) begin
              state <= HIGH;
              pwm_h <= 1'b1;
              pwm_l <= 1'b0;
            end else begin
              state <= LOW;
              pwm_h <= 1'b0;
              pwm_l <= 1'b1;
            end
          end else begin
            dt_cnt <= dt_cnt + DTW'(1);
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
          end
        end
        HIGH: begin
          if (!raw) begin
            state  <= DT;
            dt_cnt <= '0;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
          end else begin
            pwm_h <= 1'b1;
            pwm_l <= 1'b0;
          end
        end
        LOW: begin
          if (raw) begin
            state  <= DT;
            dt_cnt <= '0;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
          end else begin
            pwm_h <= 1'b0;
            pwm_l <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          dt_cnt <= '0;
          pwm_h  <= 1'b0;
          pwm_l  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpwm_gen.sv
// ============================================================================
// tb_dpwm_gen
// ----------------------------------------------------------------------------
// Scoreboard bench for dpwm_gen with default parameters (WIDTH=10,
// PERIOD=1000, DEADTIME=4). The stimulus process drives inputs and queues the
// expected gate/pulse/shadow values for each future clock cycle, tagged with
// the cycle number. The monitor samples on the falling edge and pops every
// entry due in that cycle.
// ============================================================================
module tb_dpwm_gen;

  logic       clkm;
  logic       reset;
  logic       en;
  logic [9:0] duty_in;
  logic       pwm_h;
  logic       pwm_l;
  logic       period_start;
  logic [9:0] duty_active;

  int cyc;
  int checks;
  int failures;
  bit done;

  typedef struct {
    int    at;
    string name;
    logic  h;
    logic  l;
    bit    chkPs;
    logic  ps;
    bit    chkDa;
    int    da;
  } exp_t;

  exp_t sb[$];

  dpwm_gen #(
    .WIDTH   (10),
    .PERIOD  (1000),
    .DEADTIME(4)
  ) dut (
    .clkm        (clkm),
    .reset       (reset),
    .en          (en),
    .duty_in     (duty_in),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .period_start(period_start),
    .duty_active (duty_active)
  );

  // 10 ns clock
  initial begin
    clkm = 1'b0;
    forever #5 clkm = ~clkm;
  end

  // Cycle number: count of rising edges seen so far
  initial cyc = 0;
  always @(posedge clkm) cyc <= cyc + 1;

  // Expected {pwm_h, pwm_l} at count c of a period with duty d. "first" is
  // the period that starts from IDLE (4 dead clocks up front); otherwise the
  // period follows a steady-state period with the same duty.
  function automatic logic [1:0] expHL(int d, bit first, int c);
    if (first && c < 4) return 2'b00;
    if (d >= 1000) return 2'b10;
    if (d == 0) return 2'b01;
    if (d <= 4) return (!first && c >= 1 && c <= 4) ? 2'b00 : 2'b01;
    if (!first && c == 0) return 2'b01;
    if (!first && c <= 4) return 2'b00;
    if (c <= d) return 2'b10;
    if (c <= d + 4) return 2'b00;
    return 2'b01;
  endfunction

  task automatic pushExp(input int at, input string name, input logic h, input logic l,
                         input bit chkPs, input logic ps, input bit chkDa, input int da);
    exp_t e;
    e.at    = at;
    e.name  = name;
    e.h     = h;
    e.l     = l;
    e.chkPs = chkPs;
    e.ps    = ps;
    e.chkDa = chkDa;
    e.da    = da;
    sb.push_back(e);
  endtask

  // Queue expectations for counts cFrom..cTo of a period whose cnt==0 cycle is base
  task automatic expectPeriod(input int base, input int d, input bit first, input int cFrom,
                              input int cTo, input int da, input string name);
    logic [1:0] hl;
    for (int c = cFrom; c <= cTo; c++) begin
      hl = expHL(d, first, c);
      pushExp(base + c, name, hl[1], hl[0], (c == 0 || c == 1), (c == 0),
              (c == 0 || c == cTo), da);
    end
  endtask

  // Advance to 1 ns after the rising edge that starts cycle t
  task automatic gotoCycle(input int t);
    while (cyc < t) begin
      @(posedge clkm);
      #1;
    end
  endtask

  // Start a run from IDLE with duty word dIn (effective duty dEff), check two
  // full periods, then disable and check the idle state keeps the shadow.
  task automatic applyStimulus(input int dIn, input int dEff, input string name);
    int bb;
    duty_in = 10'(dIn);
    en      = 1'b1;
    bb      = cyc + 1;
    expectPeriod(bb, dEff, 1'b1, 0, 999, dEff, {name, "_p1"});
    expectPeriod(bb + 1000, dEff, 1'b0, 0, 999, dEff, {name, "_p2"});
    gotoCycle(bb + 1999);
    en = 1'b0;
    pushExp(bb + 2000, {name, "_off"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, dEff);
    pushExp(bb + 2001, {name, "_off"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, dEff);
    gotoCycle(bb + 2001);
  endtask

  task automatic checkOutput(input string name, input string sig, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s %s cycle=%0d actual=%0d required=%0d", name, sig, cyc, act, req);
    end
  endtask

  // Monitor: falling-edge sampling, overlap guard every cycle, scoreboard pop
  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clkm);
      checkOutput("no_overlap", "pwm_h&pwm_l", int'(pwm_h & pwm_l), 0);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        if (e.at < cyc) begin
          checkOutput(e.name, "stale_entry_cycle", e.at, cyc);
        end else begin
          checkOutput(e.name, "pwm_h", int'(pwm_h), int'(e.h));
          checkOutput(e.name, "pwm_l", int'(pwm_l), int'(e.l));
          if (e.chkPs) checkOutput(e.name, "period_start", int'(period_start), int'(e.ps));
          if (e.chkDa) checkOutput(e.name, "duty_active", int'(duty_active), e.da);
        end
      end
      if (done) begin
        checkOutput("drain", "pending_entries", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    int b;
    int b2;
    int bb;
    done    = 1'b0;
    reset   = 1'b0;
    en      = 1'b1;
    duty_in = 10'd500;

    // Held in reset with en=1 and a valid duty: everything stays at zero
    for (int t = 1; t <= 5; t++) pushExp(t, "rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    gotoCycle(5);
    en    = 1'b0;
    reset = 1'b1;
    pushExp(6, "idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    pushExp(7, "idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    gotoCycle(7);

    // duty 500 from startup; change to 250 at cnt 300 of the third period
    $display("[TB] duty 500 run with mid-period change to 250");
    en      = 1'b1;
    duty_in = 10'd500;
    b       = cyc + 1;
    expectPeriod(b,        500, 1'b1, 0, 999, 500, "d500_p1");
    expectPeriod(b + 1000, 500, 1'b0, 0, 999, 500, "d500_p2");
    expectPeriod(b + 2000, 500, 1'b0, 0, 999, 500, "d500_p3");
    expectPeriod(b + 3000, 250, 1'b0, 0, 999, 250, "d250_p4");
    expectPeriod(b + 4000, 250, 1'b0, 0, 200, 250, "d250_p5");
    gotoCycle(b + 2300);
    duty_in = 10'd250;

    // Disable while HIGH at cnt 200, then re-enable
    gotoCycle(b + 4200);
    en = 1'b0;
    for (int k = 201; k <= 205; k++)
      pushExp(b + 4000 + k, "en_off", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 250);
    gotoCycle(b + 4205);
    en = 1'b1;
    b2 = cyc + 1;
    expectPeriod(b2, 250, 1'b1, 0, 999, 250, "reen");
    gotoCycle(b2 + 999);
    en = 1'b0;
    pushExp(b2 + 1000, "reen_off", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 250);
    pushExp(b2 + 1001, "reen_off", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 250);
    gotoCycle(b2 + 1001);

    // Boundary duties
    $display("[TB] boundary duty runs");
    applyStimulus(1000, 1000, "d1000");
    applyStimulus(1023, 1000, "d1023");
    applyStimulus(0,    0,    "d0");
    applyStimulus(3,    3,    "d3");

    // Reset asserted mid-period, released with en still high
    $display("[TB] mid-period reset");
    duty_in = 10'd500;
    en      = 1'b1;
    bb      = cyc + 1;
    expectPeriod(bb, 500, 1'b1, 0, 699, 500, "pre_rst");
    gotoCycle(bb + 700);
    reset = 1'b0;
    for (int k = 700; k <= 703; k++)
      pushExp(bb + k, "rst_mid", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    gotoCycle(bb + 703);
    reset = 1'b1;
    expectPeriod(bb + 704, 500, 1'b1, 0, 9, 500, "post_rst");
    gotoCycle(bb + 720);
    done = 1'b1;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout at cycle=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
